// File: rtl/hilo_muldiv_unit_if.sv
// hilo_muldiv_unit_if: start/busy/done handshake, operands and HI/LO results of the mul/div unit
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, input busy, done, dz, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, dz, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative unsigned multu/divu plus mthi/mtlo writing the HI/LO pair
module hilo_muldiv_unit #(parameter int WIDTH = 32) (
  input logic               clk,
  input logic               reset,
  hilo_muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] t_lo;
  logic [WIDTH-1:0] rem_n;
  logic             ge;
  // multiply: {acc,mq} shifts right with a conditional add into the top half
  assign sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, dv_q} : '0);
  // divide: acc is the partial remainder, mq shifts the dividend out and the quotient in
  assign t_lo  = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
  assign ge    = acc_q[WIDTH-1] | (t_lo >= dv_q);
  assign rem_n = ge ? t_lo - dv_q : t_lo;
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    dv_d     = dv_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    if (state_q == IDLE) begin
      if (bus.start) begin
        dz_d   = bus.op == 2'b01 && bus.b == '0;
        hi_d   = bus.op == 2'b10 ? bus.a : hi_q;
        lo_d   = bus.op == 2'b11 ? bus.a : lo_q;
        done_d = bus.op[1] | dz_d;
        if (!bus.op[1] && !dz_d) begin
          state_d  = RUN;
          is_div_d = bus.op[0];
          cnt_d    = '0;
          acc_d    = '0;
          mq_d     = bus.a;
          dv_d     = bus.b;
        end
      end
    end else begin
      acc_d = is_div_q ? rem_n : sum[WIDTH:1];
      mq_d  = is_div_q ? {mq_q[WIDTH-2:0], ge} : {sum[0], mq_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        hi_d    = acc_d;
        lo_d    = mq_d;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      dv_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      dv_q     <= dv_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative unsigned multiply/divide unit that writes the HI/LO register pair.
- The ALU's mfhi/mflo operations read these registers.
- Sits beside the ALU in EX and is launched by the multu/divu/mthi/mtlo decode.
- Uses a start/busy/done handshake so the pipeline stalls while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- op  input  2  00=multu, 01=divu, 10=mthi, 11=mtlo
- a  input  WIDTH  multiplicand / dividend / mthi-mtlo source
- b  input  WIDTH  multiplier / divisor
- busy  output  1  iterative operation in flight
- done  output  1  one-cycle pulse when an operation completes
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- dz  output  1  set when the last accepted divu had b=0; cleared on the next accepted start

Behaviour:
- Reset (synchronous, any state including mid-operation):
  - state=IDLE, busy=0, done=0, dz=0, hi=0, lo=0.
  - Iteration counter and working registers cleared; the in-flight operation is discarded.
- FSM states: IDLE, RUN.
- Acceptance:
  - start=1 and busy=0 at edge E latches op, a and b.
  - dz clears at E unless the new op is divu with b=0.
  - start while busy=1 is ignored; no queuing.
- mthi/mtlo:
  - At E, hi<=a (mthi) or lo<=a (mtlo); the other register is unchanged.
  - done=1 for the cycle after E; busy stays 0; state stays IDLE.
- divu with b=0:
  - No iteration; hi and lo unchanged; dz<=1 at E.
  - done=1 for the cycle after E; busy stays 0.
- multu / divu with b!=0:
  - At E, state->RUN, busy<=1, count<=0.
  - One iteration per RUN edge, WIDTH iterations at edges E+1..E+WIDTH.
  - multu: shift-add; 2*WIDTH-bit product; hi=product[2W-1:W], lo=product[W-1:0].
  - divu: restoring division; lo=quotient, hi=remainder.
  - At edge E+WIDTH: hi/lo written, busy<=0, done<=1 (high for exactly one cycle), state->IDLE.
  - Latency from acceptance edge to results visible: WIDTH cycles (32 default).
  - busy is high for exactly WIDTH cycles.
- hi/lo hold their previous values throughout RUN; working registers are separate from hi/lo.
- Operand inputs changing during RUN have no effect.
- Back-to-back:
  - start in the cycle where done=1 is accepted, since busy=0.
  - A new mthi/mtlo there overwrites the just-written register at that edge.
- All arithmetic is unsigned and modulo widths as stated; no overflow flag.
- done is never asserted together with busy=1.

Test Plan:
- Reset then idle → hi=0, lo=0, busy=0, done=0, dz=0.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF:
  - busy high for 32 cycles; old hi/lo held during RUN.
  - Then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
- divu a=100, b=7 → after 32 cycles, lo=14, hi=2, done pulse, dz=0.
- divu a=5, b=0 with prior hi=0x11, lo=0x22:
  - done the next cycle, busy never set, dz=1.
  - hi=0x11 and lo=0x22 unchanged.
  - A following mthi a=0xABCD clears dz and gives hi=0xABCD.
- Mid-operation:
  - Start multu 3×4, pulse start with op=mtlo at cycle 10 → ignored.
  - Assert reset at cycle 20 → all outputs 0.
  - After release, mtlo a=9 gives lo=9 and done one cycle later.
- Back-to-back: multu 6×7 (lo=42), then in the done cycle start divu 42/6 → lo=7, hi=0 after a further 32 cycles.
